// File: rtl/inst_mem_loader.sv
// Instruction loader: accepts 32-bit words and writes them as 4 little-endian bytes over the following 4 cycles.
// A new word is accepted at most every 5 cycles; word_ready is held low while the bytes of a word drain.
module inst_mem_loader #(
  parameter int          MEM_BYTES = 16,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic        word_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [7:0]  word_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_WR0  = 3'd2;
  localparam logic [2:0] S_WR1  = 3'd3;
  localparam logic [2:0] S_WR2  = 3'd4;
  localparam logic [2:0] S_WR3  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  // One extra bit keeps the capacity compare correct near the top of the address space.
  localparam logic [64:0] LIMIT = {1'b0, BASE_ADDR} + 65'(MEM_BYTES);

  logic [2:0]  state;
  logic [63:0] ptr;
  logic [31:0] word_q;
  logic        last_q;
  logic        fits;

  assign fits       = ({1'b0, ptr} + 65'd4) <= LIMIT;
  assign word_ready = (state == S_WAIT);
  assign mem_we     = (state == S_WR0) || (state == S_WR1) ||
                      (state == S_WR2) || (state == S_WR3);
  assign busy       = word_ready || mem_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ptr        <= BASE_ADDR;
      word_q     <= 32'd0;
      last_q     <= 1'b0;
      mem_addr   <= 64'd0;
      mem_wdata  <= 8'd0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= 8'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_WAIT;
            ptr        <= BASE_ADDR;
            word_count <= 8'd0;
            done       <= 1'b0;
            overflow   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (word_valid) begin
            if (fits) begin
              word_q    <= word_data;
              last_q    <= word_last;
              mem_addr  <= ptr;
              mem_wdata <= word_data[7:0];
              state     <= S_WR0;
            end else begin
              overflow <= 1'b1;
              done     <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        // Address/data registers are loaded one cycle ahead of the byte strobe.
        S_WR0: begin
          mem_addr  <= ptr + 64'd1;
          mem_wdata <= word_q[15:8];
          state     <= S_WR1;
        end
        S_WR1: begin
          mem_addr  <= ptr + 64'd2;
          mem_wdata <= word_q[23:16];
          state     <= S_WR2;
        end
        S_WR2: begin
          mem_addr  <= ptr + 64'd3;
          mem_wdata <= word_q[31:24];
          state     <= S_WR3;
        end
        S_WR3: begin
          ptr        <= ptr + 64'd4;
          word_count <= word_count + 8'd1;
          if (last_q) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: expected byte writes are queued at each handshake
// and popped by a write monitor; status outputs are checked at directed points.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = 32'd0;
  logic        word_last = 1'b0;
  logic        word_ready, mem_we, busy, done, overflow;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata, word_count;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          passed = 0;
  int          fails = 0;
  int          ready_cnt = 0;
  logic [63:0] exp_ptr = 64'd0;

  always #5 clk = ~clk;

  inst_mem_loader #(.MEM_BYTES(16), .BASE_ADDR(64'd0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_last  (word_last),
    .word_ready (word_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (word_ready === 1'b1) ready_cnt++;
      if (mem_we !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check("write_when_none_expected", {63'd0, mem_we}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", {56'd0, mem_wdata}, {56'd0, e.data});
        end
      end
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    wr_t e;
    for (int k = 0; k < 4; k++) begin
      e.addr = exp_ptr + 64'(k);
      e.data = w[8*k +: 8];
      exp_q.push_back(e);
    end
    exp_ptr += 64'd4;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_ptr = 64'd0;
  endtask

  // Leaves word_valid high on return; returns 1 ns after the handshake edge.
  task automatic send(input logic [31:0] w, input logic last, input logic fit);
    int n = 0;
    word_valid = 1'b1;
    word_data  = w;
    word_last  = last;
    while (word_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("handshake_in_budget", {63'd0, (n < 100)}, 64'd1);
    @(posedge clk);
    if (fit) push_word(w);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_in_budget", {63'd0, (n < 100)}, 64'd1);
  endtask

  initial begin
    int rc0;
    fork
      monitor();
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_word_ready", word_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_word_count", word_count, 0);
    reset_n = 1'b1;

    // word_valid in IDLE has no effect
    word_valid = 1'b1;
    word_data  = 32'hDEADBEEF;
    repeat (4) begin
      @(negedge clk);
      check("idle_word_ready", word_ready, 0);
      check("idle_busy", busy, 0);
    end
    word_valid = 1'b0;

    // Single word with last, latency N+1..N+4
    pulse_start();
    check("s1_busy", busy, 1);
    send(32'h02853483, 1'b1, 1'b1);
    word_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("s1_lat_we", mem_we, 1);
    end
    @(negedge clk);
    check("s1_we_off", mem_we, 0);
    check("s1_done", done, 1);
    check("s1_busy_off", busy, 0);
    check("s1_overflow", overflow, 0);
    check("s1_word_count", word_count, 1);
    check("s1_hold_addr", mem_addr, 3);
    check("s1_pending", exp_q.size(), 0);

    // Four words back to back, word_valid held high
    word_valid = 1'b1;
    word_data  = 32'h02853483;
    word_last  = 1'b0;
    rc0 = ready_cnt;
    pulse_start();
    send(32'h02853483, 1'b0, 1'b1);
    send(32'h009A84B3, 1'b0, 1'b1);
    send(32'h00148493, 1'b0, 1'b1);
    send(32'h02953423, 1'b1, 1'b1);
    word_valid = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    check("s4_ready_cycles", ready_cnt - rc0, 4);
    check("s4_done", done, 1);
    check("s4_overflow", overflow, 0);
    check("s4_word_count", word_count, 4);
    check("s4_pending", exp_q.size(), 0);

    // Fifth word overflows capacity
    pulse_start();
    check("ov_cleared_done", done, 0);
    send(32'h02853483, 1'b0, 1'b1);
    send(32'h009A84B3, 1'b0, 1'b1);
    send(32'h00148493, 1'b0, 1'b1);
    send(32'h02953423, 1'b0, 1'b1);
    send(32'hFFFFFFFF, 1'b0, 1'b0);
    word_valid = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    check("ov_overflow", overflow, 1);
    check("ov_done", done, 1);
    check("ov_word_count", word_count, 4);
    check("ov_busy", busy, 0);
    check("ov_pending", exp_q.size(), 0);

    // Reset during WR1
    pulse_start();
    check("rr_overflow_cleared", overflow, 0);
    send(32'h11223344, 1'b1, 1'b1);
    word_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rr_mem_we", mem_we, 0);
    check("rr_mem_addr", mem_addr, 0);
    check("rr_mem_wdata", mem_wdata, 0);
    check("rr_busy", busy, 0);
    check("rr_word_ready", word_ready, 0);
    check("rr_word_count", word_count, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rr_idle_after_reset", busy, 0);
    pulse_start();
    send(32'hA1B2C3D4, 1'b1, 1'b1);
    word_valid = 1'b0;
    wait_done();
    check("rr_word_count_after", word_count, 1);
    check("rr_pending", exp_q.size(), 0);

    // start during WR2 ignored; start in DONE restarts
    pulse_start();
    send(32'h02953423, 1'b1, 1'b1);
    word_valid = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("st_word_count", word_count, 1);
    check("st_pending", exp_q.size(), 0);
    pulse_start();
    check("st_restart_count", word_count, 0);
    check("st_restart_done", done, 0);
    check("st_restart_busy", busy, 1);
    send(32'h00148493, 1'b1, 1'b1);
    word_valid = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    check("st_final_count", word_count, 1);
    check("st_final_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
